// File: rtl/tlb_mutex_arb.sv
// ---------------------------------------------------------------------------
// tlb_mutex_arb
//
// Round-robin mutex that hands the shared lTlb/sTlb lookup port to one TLB
// FSM at a time. The owner's lookup fields are muxed onto the TLB port and
// the TLB response is broadcast back to every channel. A hold watchdog
// forcibly releases a lock held too long, and a contention counter tracks
// cycles in which another channel was kept waiting.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   lock[N]                  per-channel level request (held until grant seen)
//   unlock[N]                per-channel 1-cycle release pulse
//   grant[N]                 registered one-hot owner, zero when free
//   mutex_free               1 when no channel owns the port
//   ch_addr/pid/wr/valid     per-channel lookup fields (ch i at slice i)
//   tlb_addr/pid/wr/valid    owner's lookup fields to the TLB controller
//   tlb_data, tlb_hit        TLB response
//   ch_data, ch_hit          TLB response broadcast to all channels
//   timeout                  1-cycle pulse on a forced release
//   timeout_id               channel last forcibly released
//   contention_cnt           LOCKED cycles with another lock pending (wraps)
// ---------------------------------------------------------------------------
module tlb_mutex_arb #(
    parameter int N_CHAN    = 2,
    parameter int ADDR_BITS = 48,
    parameter int PID_W     = 6,
    parameter int DATA_BITS = 64,
    parameter int HOLD_MAX  = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_CHAN-1:0]             lock,
    input  logic [N_CHAN-1:0]             unlock,
    output logic [N_CHAN-1:0]             grant,
    output logic                          mutex_free,
    input  logic [N_CHAN*ADDR_BITS-1:0]   ch_addr,
    input  logic [N_CHAN*PID_W-1:0]       ch_pid,
    input  logic [N_CHAN-1:0]             ch_wr,
    input  logic [N_CHAN-1:0]             ch_valid,
    output logic [ADDR_BITS-1:0]          tlb_addr,
    output logic [PID_W-1:0]              tlb_pid,
    output logic                          tlb_wr,
    output logic                          tlb_valid,
    input  logic [DATA_BITS-1:0]          tlb_data,
    input  logic                          tlb_hit,
    output logic [DATA_BITS-1:0]          ch_data,
    output logic                          ch_hit,
    output logic                          timeout,
    output logic [$clog2(N_CHAN)-1:0]     timeout_id,
    output logic [31:0]                   contention_cnt
);

    localparam int ID_W   = $clog2(N_CHAN);
    localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam bit WD_EN  = (HOLD_MAX > 0);
    // Last LOCKED cycle the owner is allowed before a forced release.
    localparam logic [HOLD_W-1:0] HOLD_LAST = WD_EN ? HOLD_W'(HOLD_MAX - 1) : '0;

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } state_e;

    state_e              state_q,          state_d;
    logic [N_CHAN-1:0]   grant_q,          grant_d;
    logic [ID_W-1:0]     owner_q,          owner_d;
    logic [ID_W-1:0]     rr_ptr_q,         rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q,       hold_cnt_d;
    logic                timeout_q,        timeout_d;
    logic [ID_W-1:0]     timeout_id_q,     timeout_id_d;
    logic [31:0]         contention_cnt_q, contention_cnt_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand;
    logic                wd_expired;

    // (base + off) mod N_CHAN, for channel indices that need not be a power of two.
    function automatic logic [ID_W-1:0] chan_add(input logic [ID_W-1:0] base, input int off);
        int unsigned s;
        s = (32'(base) + off) % N_CHAN;
        return ID_W'(s);
    endfunction

    // Round-robin pick: first requester at or after rr_ptr, scanning cyclically.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            cand = chan_add(rr_ptr_q, i);
            if (!pick_found && lock[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign wd_expired = WD_EN && (hold_cnt_q == HOLD_LAST);

    // Next-state logic.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        owner_d          = owner_q;
        rr_ptr_d         = rr_ptr_q;
        hold_cnt_d       = hold_cnt_q;
        timeout_d        = 1'b0;
        timeout_id_d     = timeout_id_q;
        contention_cnt_d = contention_cnt_q;

        case (state_q)
            ST_FREE: begin
                if (pick_found) begin
                    state_d    = ST_LOCKED;
                    owner_d    = pick_idx;
                    grant_d    = N_CHAN'(1) << pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if ((lock & ~grant_q) != '0) begin
                    contention_cnt_d = contention_cnt_q + 32'd1;
                end
                // A real unlock takes priority over the watchdog in the same cycle.
                if (unlock[owner_q]) begin
                    state_d  = ST_FREE;
                    grant_d  = '0;
                    rr_ptr_d = chan_add(owner_q, 1);
                end else if (wd_expired) begin
                    state_d      = ST_FREE;
                    grant_d      = '0;
                    rr_ptr_d     = chan_add(owner_q, 1);
                    timeout_d    = 1'b1;
                    timeout_id_d = owner_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_FREE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!aresetn) begin
            state_q          <= ST_FREE;
            grant_q          <= '0;
            owner_q          <= '0;
            rr_ptr_q         <= '0;
            hold_cnt_q       <= '0;
            timeout_q        <= 1'b0;
            timeout_id_q     <= '0;
            contention_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            owner_q          <= owner_d;
            rr_ptr_q         <= rr_ptr_d;
            hold_cnt_q       <= hold_cnt_d;
            timeout_q        <= timeout_d;
            timeout_id_q     <= timeout_id_d;
            contention_cnt_q <= contention_cnt_d;
        end
    end

    // Lookup mux: only the registered owner's fields reach the TLB.
    always_comb begin
        tlb_addr  = '0;
        tlb_pid   = '0;
        tlb_wr    = 1'b0;
        tlb_valid = 1'b0;
        if (state_q == ST_LOCKED) begin
            tlb_addr  = ch_addr[32'(owner_q) * ADDR_BITS +: ADDR_BITS];
            tlb_pid   = ch_pid[32'(owner_q) * PID_W +: PID_W];
            tlb_wr    = ch_wr[owner_q];
            tlb_valid = ch_valid[owner_q];
        end
    end

    assign grant          = grant_q;
    assign mutex_free     = (state_q == ST_FREE);
    assign timeout        = timeout_q;
    assign timeout_id     = timeout_id_q;
    assign contention_cnt = contention_cnt_q;
    assign ch_data        = tlb_data;
    assign ch_hit         = tlb_hit;

endmodule

// File: tb/tb_tlb_mutex_arb.sv
// ---------------------------------------------------------------------------
// tb_tlb_mutex_arb
//
// Bench for tlb_mutex_arb with 4 channels and an 8-cycle hold watchdog.
// Each step drives inputs, advances a behavioural model, queues the expected
// outputs, then pops and compares them one time unit after the clock edge.
// Directed checks on top cover the documented scenarios.
// ---------------------------------------------------------------------------
module tb_tlb_mutex_arb;

    localparam int N    = 4;
    localparam int AW   = 48;
    localparam int PW   = 6;
    localparam int DW   = 64;
    localparam int HOLD = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      lock, unlock, grant;
    logic              mutex_free;
    logic [N*AW-1:0]   ch_addr;
    logic [N*PW-1:0]   ch_pid;
    logic [N-1:0]      ch_wr, ch_valid;
    logic [AW-1:0]     tlb_addr;
    logic [PW-1:0]     tlb_pid;
    logic              tlb_wr, tlb_valid;
    logic [DW-1:0]     tlb_data, ch_data;
    logic              tlb_hit, ch_hit;
    logic              timeout;
    logic [1:0]        timeout_id;
    logic [31:0]       contention_cnt;

    tlb_mutex_arb #(
        .N_CHAN(N), .ADDR_BITS(AW), .PID_W(PW), .DATA_BITS(DW), .HOLD_MAX(HOLD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .lock(lock), .unlock(unlock), .grant(grant), .mutex_free(mutex_free),
        .ch_addr(ch_addr), .ch_pid(ch_pid), .ch_wr(ch_wr), .ch_valid(ch_valid),
        .tlb_addr(tlb_addr), .tlb_pid(tlb_pid), .tlb_wr(tlb_wr), .tlb_valid(tlb_valid),
        .tlb_data(tlb_data), .tlb_hit(tlb_hit), .ch_data(ch_data), .ch_hit(ch_hit),
        .timeout(timeout), .timeout_id(timeout_id), .contention_cnt(contention_cnt)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected post-edge outputs.
    typedef struct {
        logic [N-1:0]  grant;
        logic          free;
        logic          timeout;
        logic [1:0]    tid;
        logic [31:0]   cnt;
        logic [AW-1:0] addr;
        logic          valid;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state.
    bit          m_locked;
    int          m_owner, m_rr, m_hold, m_tid;
    bit          m_to;
    logic [31:0] m_cnt;

    task automatic model(input logic r, input logic [N-1:0] lk, input logic [N-1:0] ul);
        logic [N-1:0] own_mask;
        if (!r) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_hold = 0;
            m_to = 0; m_tid = 0; m_cnt = '0;
            return;
        end
        m_to = 0;
        if (!m_locked) begin
            for (int i = 0; i < N; i++) begin
                int c = (m_rr + i) % N;
                if (lk[c]) begin
                    m_locked = 1; m_owner = c; m_hold = 0;
                    break;
                end
            end
        end else begin
            own_mask = N'(1) << m_owner;
            if ((lk & ~own_mask) != 0) m_cnt = m_cnt + 1;
            if (ul[m_owner]) begin
                m_locked = 0; m_rr = (m_owner + 1) % N;
            end else if (m_hold == HOLD - 1) begin
                m_locked = 0; m_rr = (m_owner + 1) % N;
                m_to = 1; m_tid = m_owner;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic rst_v, input logic [N-1:0] lk, input logic [N-1:0] ul);
        exp_t e;
        aresetn = rst_v;
        lock    = lk;
        unlock  = ul;
        model(rst_v, lk, ul);
        e.grant   = m_locked ? (N'(1) << m_owner) : '0;
        e.free    = !m_locked;
        e.timeout = m_to;
        e.tid     = 2'(m_tid);
        e.cnt     = m_cnt;
        e.addr    = m_locked ? ch_addr[m_owner*AW +: AW] : '0;
        e.valid   = m_locked ? ch_valid[m_owner] : 1'b0;
        sb.push_back(e);
        @(posedge aclk);
        #1;
        e = sb.pop_front();
        check($sformatf("%s.grant", phase),      grant,          e.grant);
        check($sformatf("%s.free", phase),       mutex_free,     e.free);
        check($sformatf("%s.timeout", phase),    timeout,        e.timeout);
        check($sformatf("%s.timeout_id", phase), timeout_id,     e.tid);
        check($sformatf("%s.cnt", phase),        contention_cnt, e.cnt);
        check($sformatf("%s.tlb_addr", phase),   tlb_addr,       e.addr);
        check($sformatf("%s.tlb_valid", phase),  tlb_valid,      e.valid);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int n_hold;
        aresetn = 1'b0; lock = '0; unlock = '0;
        ch_addr = '0; ch_pid = '0; ch_wr = '0; ch_valid = '0;
        tlb_data = '0; tlb_hit = 1'b0;

        // Reset values.
        phase = "reset";
        step(0, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000);
        check("reset.grant", grant, 0);
        check("reset.free", mutex_free, 1);
        check("reset.timeout", timeout, 0);
        check("reset.timeout_id", timeout_id, 0);
        check("reset.cnt", contention_cnt, 0);

        // Two requesters: ch0 first, one FREE cycle, then ch1.
        phase = "two_ch";
        step(1, 4'b0011, 4'b0000);
        check("two_ch.first", grant, 4'b0001);
        step(1, 4'b0010, 4'b0001);
        check("two_ch.gap_free", mutex_free, 1);
        check("two_ch.gap_grant", grant, 0);
        step(1, 4'b0010, 4'b0000);
        check("two_ch.second", grant, 4'b0010);
        step(1, 4'b0000, 4'b0010);

        // Round robin with all four locks held; owner unlocks on its third LOCKED cycle.
        phase = "rr";
        step(0, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(1, 4'b1111, 4'b0000);
            check($sformatf("rr.order%0d", k), grant, 4'b0001 << (k % 4));
            step(1, 4'b1111, 4'b0000);
            step(1, 4'b1111, 4'b0000);
            step(1, 4'b1111, 4'b0001 << (k % 4));
        end
        check("rr.contention", contention_cnt, 15);
        step(1, 4'b0000, 4'b0000);

        // Watchdog: ch2 never unlocks.
        phase = "wdog";
        step(1, 4'b0100, 4'b0000);
        check("wdog.grant", grant, 4'b0100);
        n_hold = 0;
        for (int i = 0; i < 20 && !mutex_free; i++) begin
            step(1, 4'b0000, 4'b0000);
            n_hold++;
        end
        check("wdog.locked_cycles", n_hold, 8);
        check("wdog.pulse", timeout, 1);
        check("wdog.id", timeout_id, 2);
        check("wdog.grant_after", grant, 0);
        step(1, 4'b0000, 4'b0000);
        check("wdog.pulse_end", timeout, 0);
        check("wdog.id_held", timeout_id, 2);

        // Unlock on the last allowed cycle wins over the watchdog.
        phase = "race";
        step(1, 4'b0010, 4'b0000);
        check("race.grant", grant, 4'b0010);
        repeat (7) step(1, 4'b0000, 4'b0000);
        check("race.still_held", grant, 4'b0010);
        step(1, 4'b0000, 4'b0010);
        check("race.no_timeout", timeout, 0);
        check("race.free", mutex_free, 1);

        // Lookup mux and response broadcast.
        phase = "mux";
        ch_addr[1*AW +: AW] = 48'h1000;
        ch_addr[0*AW +: AW] = 48'h2000;
        ch_pid[1*PW +: PW]  = 6'h15;
        ch_wr               = 4'b0010;
        ch_valid            = 4'b0011;
        tlb_data            = 64'hdead_beef_0123_4567;
        tlb_hit             = 1'b1;
        #1;
        check("mux.free_valid", tlb_valid, 0);
        check("mux.free_addr", tlb_addr, 0);
        check("mux.ch_data", ch_data, 64'hdead_beef_0123_4567);
        check("mux.ch_hit", ch_hit, 1);
        step(1, 4'b0010, 4'b0000);
        check("mux.addr", tlb_addr, 48'h1000);
        check("mux.valid", tlb_valid, 1);
        check("mux.pid", tlb_pid, 6'h15);
        check("mux.wr", tlb_wr, 1);
        step(1, 4'b0011, 4'b0000);
        check("mux.owner_kept", tlb_addr, 48'h1000);
        // Owner releases and re-requests together: it drops to lowest priority.
        step(1, 4'b0011, 4'b0010);
        check("mux.release_free", mutex_free, 1);
        step(1, 4'b0011, 4'b0000);
        check("mux.recompete", grant, 4'b0001);
        check("mux.addr_ch0", tlb_addr, 48'h2000);
        step(1, 4'b0000, 4'b0001);

        // Reset while ch3 owns the lock.
        phase = "midrst";
        ch_valid = '0;
        step(1, 4'b1000, 4'b0000);
        check("midrst.owner", grant, 4'b1000);
        step(0, 4'b1010, 4'b0000);
        check("midrst.grant", grant, 0);
        check("midrst.free", mutex_free, 1);
        check("midrst.cnt", contention_cnt, 0);
        step(1, 4'b1010, 4'b0000);
        check("midrst.rearb", grant, 4'b0010);
        step(1, 4'b0000, 4'b0010);
        step(1, 4'b0000, 4'b0000);

        check("scoreboard.drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
